// File: rtl/median_arbiter_if.sv
// Bus between the median arbiter, its two requesters and the shared median unit.
// Groups requester write/result signals, the median unit burst port and debug state.
interface median_arbiter_if #(
  parameter int TAILLE = 8
);
  // Handshake: X_WE is taken on a rising edge only while X_BUSY is low. X_BUSY rises the
  // cycle after the ninth accepted write and falls together with the X_DSO pulse, or after
  // an ERR abort. M_DSI/M_DI carry one 9-beat burst. M_DSO is a one-cycle result strobe,
  // honoured only while a result is awaited. X_DSO and ERR are one-cycle pulses.
  logic              A_WE;
  logic [TAILLE-1:0] A_DI;
  logic              A_BUSY;
  logic [TAILLE-1:0] A_DO;
  logic              A_DSO;

  logic              B_WE;
  logic [TAILLE-1:0] B_DI;
  logic              B_BUSY;
  logic [TAILLE-1:0] B_DO;
  logic              B_DSO;

  logic              M_DSI;
  logic [TAILLE-1:0] M_DI;
  logic [TAILLE-1:0] M_DO;
  logic              M_DSO;

  logic              ERR;
  logic [1:0]        dbg_state;

  modport slave (
    input  A_WE, A_DI, B_WE, B_DI, M_DO, M_DSO,
    output A_BUSY, A_DO, A_DSO, B_BUSY, B_DO, B_DSO, M_DSI, M_DI, ERR, dbg_state
  );

  modport master (
    output A_WE, A_DI, B_WE, B_DI, M_DO, M_DSO,
    input  A_BUSY, A_DO, A_DSO, B_BUSY, B_DO, B_DSO, M_DSI, M_DI, ERR, dbg_state
  );
endinterface

// File: rtl/median_arbiter.sv
// Shares one 9-input median unit between requesters A and B: private sample buffers,
// round-robin grant, 9-beat burst sender, result return and a watchdog abort.
module median_arbiter #(
  parameter int TAILLE  = 8,
  parameter int TIMEOUT = 63
) (
  input  logic            CLK,
  input  logic            nRST,
  median_arbiter_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  localparam logic [3:0] LAST_IDX = 4'd8;
  localparam logic [7:0] WD_LAST  = 8'(TIMEOUT - 1);

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic [7:0]        r_wd;
  logic              r_gnt;
  logic              r_last;

  logic [TAILLE-1:0] r_buf_a [9];
  logic [TAILLE-1:0] r_buf_b [9];
  logic [3:0]        r_ptr_a;
  logic [3:0]        r_ptr_b;
  logic              r_pend_a;
  logic              r_pend_b;

  logic [TAILLE-1:0] r_do_a;
  logic [TAILLE-1:0] r_do_b;
  logic              r_dso_a;
  logic              r_dso_b;
  logic              r_err;

  logic              w_wr_a;
  logic              w_wr_b;
  logic              w_done;
  logic              w_abort;
  logic              w_clr_a;
  logic              w_clr_b;
  logic              w_pick_b;
  logic [TAILLE-1:0] w_send_data;

  assign w_wr_a  = bus.A_WE & ~r_pend_a;
  assign w_wr_b  = bus.B_WE & ~r_pend_b;
  assign w_done  = (r_state == S_WAIT) & bus.M_DSO;
  assign w_abort = (r_state == S_WAIT) & ~bus.M_DSO & (r_wd == WD_LAST);
  assign w_clr_a = (w_done | w_abort) & ~r_gnt;
  assign w_clr_b = (w_done | w_abort) & r_gnt;

  // r_last is 1 when B was served last; B wins only if alone or A was served last.
  assign w_pick_b = r_pend_b & (~r_pend_a | ~r_last);

  assign w_send_data = r_gnt ? r_buf_b[r_cnt] : r_buf_a[r_cnt];

  // Requester A: buffer pointer and pending flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_ptr_a  <= '0;
      r_pend_a <= 1'b0;
    end else if (w_clr_a) begin
      r_ptr_a  <= '0;
      r_pend_a <= 1'b0;
    end else if (w_wr_a) begin
      if (r_ptr_a == LAST_IDX) begin
        r_ptr_a  <= '0;
        r_pend_a <= 1'b1;
      end else begin
        r_ptr_a <= r_ptr_a + 4'd1;
      end
    end
  end

  // Requester B: buffer pointer and pending flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_ptr_b  <= '0;
      r_pend_b <= 1'b0;
    end else if (w_clr_b) begin
      r_ptr_b  <= '0;
      r_pend_b <= 1'b0;
    end else if (w_wr_b) begin
      if (r_ptr_b == LAST_IDX) begin
        r_ptr_b  <= '0;
        r_pend_b <= 1'b1;
      end else begin
        r_ptr_b <= r_ptr_b + 4'd1;
      end
    end
  end

  // Sample storage is plain data and needs no reset.
  always_ff @(posedge CLK) begin
    if (w_wr_a) begin
      r_buf_a[r_ptr_a] <= bus.A_DI;
    end
    if (w_wr_b) begin
      r_buf_b[r_ptr_b] <= bus.B_DI;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_wd    <= '0;
      r_gnt   <= 1'b0;
      r_last  <= 1'b1;
      r_do_a  <= '0;
      r_do_b  <= '0;
      r_dso_a <= 1'b0;
      r_dso_b <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_dso_a <= 1'b0;
      r_dso_b <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_pend_a | r_pend_b) begin
            r_gnt   <= w_pick_b;
            r_cnt   <= '0;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          if (r_cnt == LAST_IDX) begin
            r_wd    <= '0;
            r_state <= S_WAIT;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_WAIT: begin
          if (bus.M_DSO) begin
            if (r_gnt) begin
              r_do_b  <= bus.M_DO;
              r_dso_b <= 1'b1;
            end else begin
              r_do_a  <= bus.M_DO;
              r_dso_a <= 1'b1;
            end
            r_last  <= r_gnt;
            r_state <= S_GAP;
          end else if (r_wd == WD_LAST) begin
            r_err   <= 1'b1;
            r_last  <= r_gnt;
            r_state <= S_GAP;
          end else begin
            r_wd <= r_wd + 8'd1;
          end
        end
        S_GAP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Burst outputs decode straight from state so a reset drops M_DSI immediately.
  assign bus.M_DSI     = (r_state == S_SEND);
  assign bus.M_DI      = (r_state == S_SEND) ? w_send_data : '0;
  assign bus.A_BUSY    = r_pend_a;
  assign bus.B_BUSY    = r_pend_b;
  assign bus.A_DO      = r_do_a;
  assign bus.B_DO      = r_do_b;
  assign bus.A_DSO     = r_dso_a;
  assign bus.B_DSO     = r_dso_b;
  assign bus.ERR       = r_err;
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_median_arbiter.sv
// Bench for median_arbiter: behavioural median unit, per-requester expected-result
// queues, directed scenarios followed by randomized loads.
module tb_median_arbiter;
  localparam int W  = 8;
  localparam int TO = 20;
  typedef logic [W-1:0] samp_t [9];

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  median_arbiter_if #(.TAILLE(W)) bus();

  median_arbiter #(.TAILLE(W), .TIMEOUT(TO)) dut (
    .CLK  (clk),
    .nRST (rst_n),
    .bus  (bus.slave)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] med9(input samp_t s);
    samp_t t;
    logic [W-1:0] x;
    t = s;
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (t[j] > t[j+1]) begin
          x = t[j]; t[j] = t[j+1]; t[j+1] = x;
        end
    return t[4];
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];
  int a_dso_n = 0, b_dso_n = 0, err_n = 0;
  int a_dso_cyc = 0, b_dso_cyc = 0, err_cyc = 0;
  bit err_ok = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.A_DSO) begin
        a_dso_n++; a_dso_cyc = cyc;
        if (exp_a_q.size() == 0) check("a_dso_unexpected", bus.A_DSO, 0);
        else check("a_do", bus.A_DO, exp_a_q.pop_front());
      end
      if (bus.B_DSO) begin
        b_dso_n++; b_dso_cyc = cyc;
        if (exp_b_q.size() == 0) check("b_dso_unexpected", bus.B_DSO, 0);
        else check("b_do", bus.B_DO, exp_b_q.pop_front());
      end
      if (bus.ERR) begin
        err_n++; err_cyc = cyc;
        if (!err_ok) check("err_unexpected", bus.ERR, 0);
      end
    end
  end

  // ---------------- behavioural median unit ----------------
  logic [W-1:0] burst_q[$];
  samp_t last_burst;
  int burst_start = 0, burst_end = 0, prev_end = 0;
  int med_cd = 0, fix_lat = -1;
  bit med_busy = 0, med_en = 1, spur_req = 0, saw_ff = 0;
  logic [W-1:0] med_val;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_q.delete();
      med_busy  = 0;
      bus.M_DSO = 1'b0;
      bus.M_DO  = '0;
    end else begin
      bus.M_DSO = 1'b0;
      bus.M_DO  = W'($urandom);
      if (bus.M_DSI) begin
        if (burst_q.size() == 0) burst_start = cyc;
        burst_q.push_back(bus.M_DI);
        if (bus.M_DI == 8'hFF) saw_ff = 1;
      end else begin
        check("m_di_idle_zero", bus.M_DI, 0);
        if (burst_q.size() != 0) begin
          check("burst_len", burst_q.size(), 9);
          for (int i = 0; i < 9; i++) last_burst[i] = (i < burst_q.size()) ? burst_q[i] : '0;
          prev_end  = burst_end;
          burst_end = cyc - 1;
          burst_q.delete();
          if (med_en) begin
            med_busy = 1;
            med_cd   = (fix_lat >= 0) ? fix_lat : $urandom_range(0, 4);
            med_val  = med9(last_burst);
          end
        end
      end
      if (med_busy) begin
        if (med_cd == 0) begin
          bus.M_DSO = 1'b1; bus.M_DO = med_val; med_busy = 0;
        end else med_cd--;
      end else if (spur_req) begin
        bus.M_DSO = 1'b1; bus.M_DO = 8'h77; spur_req = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic drive(input bit wa, input logic [W-1:0] da, input bit wb, input logic [W-1:0] db);
    bus.A_WE = wa; bus.A_DI = da; bus.B_WE = wb; bus.B_DI = db;
    tick();
    bus.A_WE = 1'b0; bus.B_WE = 1'b0;
  endtask

  // sel: 0 = A only, 1 = B only, 2 = both in the same cycles
  task automatic load9(input int sel, input samp_t sa, input samp_t sb);
    for (int i = 0; i < 9; i++) drive(sel != 1, sa[i], sel != 0, sb[i]);
    if (sel != 1) exp_a_q.push_back(med9(sa));
    if (sel != 0) exp_b_q.push_back(med9(sb));
  endtask

  task automatic rand9(output samp_t s, input int maxv);
    for (int i = 0; i < 9; i++) s[i] = W'($urandom_range(0, maxv));
  endtask

  task automatic wait_dso(input bit is_b, input string tag);
    int start, n;
    start = is_b ? b_dso_n : a_dso_n;
    n = 0;
    while ((is_b ? b_dso_n : a_dso_n) == start && n < 300) begin tick(); n++; end
    check(tag, is_b ? b_dso_n : a_dso_n, start + 1);
  endtask

  task automatic wait_dsi(input string tag);
    int n = 0;
    while (!bus.M_DSI && n < 100) begin tick(); n++; end
    check(tag, bus.M_DSI, 1);
  endtask

  task automatic wait_free(input int sel);
    int n = 0;
    while (((sel != 1) && bus.A_BUSY) || ((sel != 0) && bus.B_BUSY)) begin
      if (n > 300) break;
      tick(); n++;
    end
    check("wait_free", {bus.A_BUSY && sel != 1, bus.B_BUSY && sel != 0}, 0);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_a_q.size() != 0 || exp_b_q.size() != 0 || bus.A_BUSY || bus.B_BUSY || bus.M_DSI) && n < 600) begin
      tick(); n++;
    end
    check(tag, exp_a_q.size() + exp_b_q.size() + 32'(bus.A_BUSY) + 32'(bus.B_BUSY), 0);
    tick(2);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    exp_a_q.delete(); exp_b_q.delete();
    rst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    samp_t sa, sb, zs;
    logic [W-1:0] hold_a;
    int n0, gap;
    for (int i = 0; i < 9; i++) zs[i] = '0;
    bus.A_WE = 0; bus.A_DI = 0; bus.B_WE = 0; bus.B_DI = 0;
    rst_n = 1'b0;
    tick(3);
    check("rst_a_busy", bus.A_BUSY, 0);
    check("rst_b_busy", bus.B_BUSY, 0);
    check("rst_a_dso",  bus.A_DSO, 0);
    check("rst_b_dso",  bus.B_DSO, 0);
    check("rst_a_do",   bus.A_DO, 0);
    check("rst_b_do",   bus.B_DO, 0);
    check("rst_m_dsi",  bus.M_DSI, 0);
    check("rst_m_di",   bus.M_DI, 0);
    check("rst_err",    bus.ERR, 0);
    rst_n = 1'b1;
    tick(2);

    // Single A transaction 9..1, latency and burst order
    for (int i = 0; i < 9; i++) sa[i] = W'(9 - i);
    load9(0, sa, zs);
    check("t1_busy_after_9th", bus.A_BUSY, 1);
    check("t1_dsi_not_yet", bus.M_DSI, 0);
    tick();
    check("t1_dsi_2cyc", bus.M_DSI, 1);
    check("t1_first_di", bus.M_DI, 9);
    wait_dso(0, "t1_a_dso");
    check("t1_a_do", bus.A_DO, 5);
    check("t1_busy_clear", bus.A_BUSY, 0);
    for (int i = 0; i < 9; i++) check("t1_burst_order", last_burst[i], 9 - i);
    check("t1_b_dso_quiet", b_dso_n, 0);
    n0 = a_dso_n;
    tick();
    check("t1_dso_one_pulse", bus.A_DSO, 0);
    rand9(sa, 255);
    load9(0, sa, zs);
    wait_dso(0, "t1_reload_dso");
    wait_drain("t1_drain");

    // Stray M_DSO while idle is ignored
    hold_a = bus.A_DO;
    n0 = a_dso_n + b_dso_n;
    spur_req = 1;
    tick(4);
    check("spur_no_dso", a_dso_n + b_dso_n, n0);
    check("spur_a_do_hold", bus.A_DO, hold_a);

    // Simultaneous fill right after reset: A first, then B
    do_reset();
    for (int i = 0; i < 9; i++) begin sa[i] = W'(i + 1); sb[i] = W'(i + 20); end
    load9(2, sa, sb);
    wait_dso(1, "t2_b_dso");
    check("t2_a_before_b", a_dso_cyc < b_dso_cyc, 1);
    check("t2_a_do", bus.A_DO, 5);
    check("t2_b_do", bus.B_DO, 24);
    gap = burst_start - prev_end - 1;
    check("t2_gap_ge2", gap >= 2, 1);
    wait_drain("t2_drain");

    // A refills right after its result while B already pending: B served next
    fix_lat = 15;
    rand9(sa, 255); rand9(sb, 255);
    load9(0, sa, zs);
    wait_dsi("t3_a_grant");
    load9(1, zs, sb);
    wait_dso(0, "t3_a_dso");
    rand9(sa, 255);
    load9(0, sa, zs);
    fix_lat = -1;
    wait_dso(0, "t3_a2_dso");
    check("t3_b_before_a2", b_dso_cyc < a_dso_cyc, 1);
    wait_drain("t3_drain");

    // Tie with A served last: B wins
    rand9(sa, 255); rand9(sb, 255);
    load9(2, sa, sb);
    wait_dso(0, "t3b_a_dso");
    check("t3b_b_first", b_dso_cyc < a_dso_cyc, 1);
    wait_drain("t3b_drain");

    // Tenth write while busy is dropped
    saw_ff = 0;
    rand9(sa, 254);
    for (int i = 0; i < 9; i++) drive(1, sa[i], 0, '0);
    check("t4_busy_after_9th", bus.A_BUSY, 1);
    drive(1, 8'hFF, 0, '0);
    exp_a_q.push_back(med9(sa));
    wait_dso(0, "t4_a_dso");
    check("t4_no_ff", saw_ff, 0);
    wait_drain("t4_drain");

    // Watchdog abort of A, then pending B served
    med_en = 0; err_ok = 1;
    hold_a = bus.A_DO;
    n0 = a_dso_n;
    rand9(sa, 255); rand9(sb, 255);
    load9(0, sa, zs);
    wait_dsi("t5_a_grant");
    load9(1, zs, sb);
    begin
      int e0 = err_n, n = 0;
      while (err_n == e0 && n < 100) begin tick(); n++; end
      check("t5_err_seen", err_n, e0 + 1);
    end
    check("t5_err_timing", err_cyc - burst_end, TO + 1);
    check("t5_a_busy_clear", bus.A_BUSY, 0);
    check("t5_no_a_dso", a_dso_n, n0);
    check("t5_a_do_hold", bus.A_DO, hold_a);
    void'(exp_a_q.pop_front());
    med_en = 1;
    tick();
    check("t5_err_one_pulse", bus.ERR, 0);
    err_ok = 0;
    wait_dso(1, "t5_b_dso");
    wait_drain("t5_drain");

    // Reset in the middle of a burst
    rand9(sa, 255); rand9(sb, 255);
    load9(2, sa, sb);
    wait_dsi("t6_grant");
    tick(4);
    check("t6_cnt4_data", bus.M_DI, sa[4]);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_dsi_drop", bus.M_DSI, 0);
    check("t6_a_busy", bus.A_BUSY, 0);
    check("t6_b_busy", bus.B_BUSY, 0);
    exp_a_q.delete(); exp_b_q.delete();
    tick(2);
    rst_n = 1'b1;
    tick(2);
    rand9(sa, 255);
    load9(0, sa, zs);
    wait_dso(0, "t6_fresh_dso");
    wait_drain("t6_drain");

    // Randomized loads
    for (int k = 0; k < 12; k++) begin
      int sel = $urandom_range(0, 2);
      wait_free(sel);
      rand9(sa, 255); rand9(sb, 255);
      load9(sel, sa, sb);
      tick($urandom_range(0, 3));
    end
    wait_drain("rand_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/median_arbiter.md
Name: median_arbiter

Overview:
- Shares one 9-input median unit (MEDIAN, DSI/DI in, DO/DSO out) between two independent requesters, A and B.
- Each requester loads 9 samples into its own private buffer.
- The arbiter picks a full buffer using round-robin, streams its 9 samples into the median unit as one DSI burst, waits for DSO, and returns the result to that requester.
- A watchdog drops any transaction whose result never arrives.

Parameters:
- TAILLE, 8: sample/result width in bits.
- TIMEOUT, 63: max cycles in WAIT before the transaction is aborted (legal range 16..255).

Ports:
- CLK  in  1  clock, all logic on rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- A_WE  in  1  requester A write strobe.
- A_DI  in  TAILLE  requester A sample.
- A_BUSY  out  1  A buffer full or in flight; writes are ignored while high.
- A_DO  out  TAILLE  median result for A.
- A_DSO  out  1  one-cycle pulse, A_DO valid.
- B_WE, B_DI, B_BUSY, B_DO, B_DSO: same as A, for requester B.
- M_DSI  out  1  to median unit DSI.
- M_DI  out  TAILLE  to median unit DI.
- M_DO  in  TAILLE  from median unit DO.
- M_DSO  in  1  from median unit DSO.
- ERR  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (nRST low, asynchronous):
  - All outputs 0; write pointers 0; pending flags 0; state IDLE.
  - Round-robin pointer set so A wins the first tie.
  - Takes effect mid-transaction too: M_DSI drops the same instant.
  - The same nRST drives the median unit's reset.
- Per-requester buffer:
  - 9 x TAILLE entries plus a write pointer 0..8.
  - X_WE=1 with X_BUSY=0 writes X_DI at the pointer and increments the pointer.
  - The write at pointer 8 sets pending; X_BUSY goes high the next cycle.
  - X_BUSY stays high until that requester's X_DSO pulse or abort; then pointer=0 and pending=0.
  - X_WE while busy is dropped silently; buffer contents are unchanged.
- State machine: IDLE, SEND, WAIT, GAP.
  - IDLE:
    - If exactly one pending: grant it.
    - If both pending: grant the requester not served last.
    - On grant: go to SEND, cnt=0.
    - A pending flag set this cycle is seen next cycle.
  - SEND:
    - M_DSI=1 and M_DI=buf[cnt] for exactly 9 consecutive cycles, cnt 0..8, in write order.
    - After cnt=8: go to WAIT, M_DSI=0, watchdog=0.
  - WAIT:
    - M_DSO=1: register M_DO into X_DO of the granted requester.
    - X_DSO pulses on the cycle after M_DSO; pending is cleared; round-robin pointer updated; go to GAP.
    - Watchdog reaches TIMEOUT without M_DSO: ERR pulses 1 cycle; granted request is dropped (pending cleared, no X_DSO, X_DO unchanged); round-robin updated; go to GAP.
  - GAP: exactly one cycle with M_DSI=0 so the median unit returns to idle; then go to IDLE.
- M_DSO outside WAIT is ignored.
- X_DO holds its last value until the next result for that requester.
- M_DI=0 whenever M_DSI=0.
- Minimum spacing between bursts: 1 cycle of GAP + 1 cycle of IDLE.
- Simultaneous events:
  - The non-granted requester may load its buffer at any time.
  - A requester whose X_DSO pulses may write again starting the cycle X_BUSY=0.
- Latency: buffer-full to first M_DSI is 2 cycles when uncontended; M_DSO to X_DSO is 1 cycle.

Test Plan:
- A writes 9,8,7,6,5,4,3,2,1 -> M_DSI high 9 cycles carrying 9..1 in order; model median returns 5; A_DO=5; A_DSO one pulse; B_DSO stays 0; A_BUSY drops and then accepts new writes.
- A and B both fill in the same cycle after reset (A: 1..9, B: 20..28) -> A burst first, result 5; then a gap of at least 2 cycles; then B burst, result 24; B_DSO after A_DSO.
- A refills immediately after its A_DSO while B is already pending -> B granted next (round-robin); A served after B.
- A writes 10 samples, 10th=0xFF -> 0xFF never appears on M_DI; A_BUSY high from the cycle after the 9th write.
- Model median never asserts M_DSO, TIMEOUT=20 -> ERR pulses 20 cycles after WAIT entry; A_BUSY clears; A_DSO never pulses; a pending B request is then served normally.
- nRST low during SEND at cnt=4 -> M_DSI=0 and both X_BUSY=0 immediately; after release, a fresh 9-write load completes normally.
